// File: rtl/vinsn_dispatch_queue_pkg.sv
// Shared types and decode helpers for the vector instruction dispatch queue
// (instruction, VFU and operand-request payloads, VFU/queue selection).
package vinsn_dispatch_queue_pkg;

    localparam int unsigned NrVFU     = 2;
    localparam int unsigned NrOpQueue = 2;

    typedef logic [4:0] vreg_t;
    typedef logic [7:0] vrf_addr_t;
    typedef logic [7:0] vlen_t;

    typedef enum logic [0:0] {
        VFU_ALU = 1'b0,
        VFU_MUL = 1'b1
    } vfu_e;

    typedef enum logic [2:0] {
        VOP_ADD  = 3'd0,
        VOP_SUB  = 3'd1,
        VOP_AND  = 3'd2,
        VOP_OR   = 3'd3,
        VOP_MUL  = 3'd4,
        VOP_MACC = 3'd5
    } vop_e;

    typedef struct packed {
        vop_e       vop;
        vreg_t      vd;
        vreg_t      vs1;
        vreg_t      vs2;
        logic [1:0] use_vs;
        vlen_t      vl;
    } issue_req_t;

    typedef struct packed {
        vop_e      vop;
        vreg_t     vd;
        vrf_addr_t waddr;
        vlen_t     vl;
    } vfu_req_t;

    typedef struct packed {
        vreg_t                vs1;
        vreg_t                vs2;
        logic [1:0]           use_vs;
        logic [NrOpQueue-1:0] queue_req;
        vlen_t                vl;
    } op_req_t;

    function automatic vfu_e GetVFUByVOp(input vop_e vop);
        case (vop)
            VOP_MUL, VOP_MACC: return VFU_MUL;
            default:           return VFU_ALU;
        endcase
    endfunction

    // Each vector register occupies an 8-line slice of the VRF.
    function automatic vrf_addr_t GetVRFAddr(input vreg_t vd);
        return {vd, 3'b000};
    endfunction

    // Operand queue 0 streams vs1, queue 1 streams vs2.
    function automatic logic [NrOpQueue-1:0] GetOpQueue(input vop_e vop, input logic [1:0] use_vs);
        logic [NrOpQueue-1:0] q;
        q = use_vs;
        if (vop == VOP_MACC) q = use_vs;
        return q;
    endfunction

endpackage

// File: rtl/vreg_hazard_tracker.sv
// Pending-write / pending-read bitmaps over the architectural vector registers;
// flags RAW/WAW/WAR (and conservative read-read) hazards for the queue head.
module vreg_hazard_tracker
    import vinsn_dispatch_queue_pkg::*;
#(
    parameter int unsigned NrVRegs = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_i,
    input  issue_req_t            head_i,
    input  logic [NrVFU-1:0]      vfu_done_i,
    input  logic [NrVFU-1:0]      vfu_use_vd_i,
    input  vreg_t [NrVFU-1:0]     vfu_vd_i,
    input  logic [NrOpQueue-1:0]  op_access_done_i,
    input  vreg_t [NrOpQueue-1:0] op_access_vs_i,
    output logic                  hazard_o
);

    logic [NrVRegs-1:0] pending_wr_q, pending_wr_d;
    logic [NrVRegs-1:0] pending_rd_q, pending_rd_d;

    // Clears are applied first so a same-cycle set on the same register wins.
    always_comb begin
        pending_wr_d = pending_wr_q;
        pending_rd_d = pending_rd_q;
        for (int k = 0; k < NrVFU; k++) begin
            if (vfu_done_i[k] && vfu_use_vd_i[k]) pending_wr_d[vfu_vd_i[k]] = 1'b0;
        end
        for (int q = 0; q < NrOpQueue; q++) begin
            if (op_access_done_i[q]) pending_rd_d[op_access_vs_i[q]] = 1'b0;
        end
        if (set_i) begin
            pending_wr_d[head_i.vd] = 1'b1;
            if (head_i.use_vs[0]) pending_rd_d[head_i.vs1] = 1'b1;
            if (head_i.use_vs[1]) pending_rd_d[head_i.vs2] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_wr_q <= '0;
            pending_rd_q <= '0;
        end else begin
            pending_wr_q <= pending_wr_d;
            pending_rd_q <= pending_rd_d;
        end
    end

    always_comb begin
        hazard_o = pending_wr_q[head_i.vd] | pending_rd_q[head_i.vd];
        if (head_i.use_vs[0]) hazard_o = hazard_o | pending_wr_q[head_i.vs1] | pending_rd_q[head_i.vs1];
        if (head_i.use_vs[1]) hazard_o = hazard_o | pending_wr_q[head_i.vs2] | pending_rd_q[head_i.vs2];
    end

endmodule

// File: rtl/vinsn_dispatch_queue.sv
// In-order decoded-instruction FIFO with hazard-gated dispatch into one VFU request
// register and one operand request register. Perf counters: VINSN_DISPATCH_PERF_EN.
module vinsn_dispatch_queue
    import vinsn_dispatch_queue_pkg::*;
#(
    parameter int unsigned QueueDepth = 4,
    parameter int unsigned NrVRegs    = 32,
    parameter int unsigned CntWidth   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  issue_req_valid_i,
    output logic                  issue_req_ready_o,
    input  issue_req_t            issue_req_i,
    input  logic [NrVFU-1:0]      vfu_req_ready_i,
    output logic                  vfu_req_valid_o,
    output vfu_e                  target_vfu_o,
    output vfu_req_t              vfu_req_o,
    input  logic                  op_req_ready_i,
    output logic                  op_req_valid_o,
    output op_req_t               op_req_o,
    input  logic [NrVFU-1:0]      vfu_done_i,
    input  logic [NrVFU-1:0]      vfu_use_vd_i,
    input  vreg_t [NrVFU-1:0]     vfu_vd_i,
    input  logic [NrOpQueue-1:0]  op_access_done_i,
    input  vreg_t [NrOpQueue-1:0] op_access_vs_i,
    output logic                  queue_empty_o,
    output logic [CntWidth-1:0]   perf_hazard_o,
    output logic [CntWidth-1:0]   perf_backpr_o,
    output logic [CntWidth-1:0]   perf_disp_o
);

    localparam int unsigned PtrWidth   = $clog2(QueueDepth);
    localparam int unsigned CountWidth = $clog2(QueueDepth + 1);
    localparam logic [CountWidth-1:0] CountFull = CountWidth'(QueueDepth);

    issue_req_t            fifo_q [QueueDepth];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountWidth-1:0] count_q;

    logic       push, pop, head_vld, hazard;
    logic       vfu_free, op_free, slot_free;
    issue_req_t head;

    logic       vfu_vld_p1, op_vld_p1;
    vfu_e       target_p1;
    vfu_req_t   vfu_req_p1;
    op_req_t    op_req_p1;

    // Ready comes from the registered count only: a pop never frees a slot in the same cycle.
    assign issue_req_ready_o = (count_q != CountFull);
    assign push      = issue_req_valid_i && issue_req_ready_o;
    assign head_vld  = (count_q != '0);
    assign head      = fifo_q[rd_ptr_q];
    assign vfu_free  = !vfu_vld_p1 || vfu_req_ready_i[target_p1];
    assign op_free   = !op_vld_p1 || op_req_ready_i;
    assign slot_free = vfu_free && op_free;
    assign pop       = head_vld && !hazard && slot_free && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= issue_req_i;
    end

    vreg_hazard_tracker #(
        .NrVRegs (NrVRegs)
    ) i_tracker (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .set_i            (pop),
        .head_i           (head),
        .vfu_done_i       (vfu_done_i),
        .vfu_use_vd_i     (vfu_use_vd_i),
        .vfu_vd_i         (vfu_vd_i),
        .op_access_done_i (op_access_done_i),
        .op_access_vs_i   (op_access_vs_i),
        .hazard_o         (hazard)
    );

    // ---- stage p1: registered VFU and operand requests ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vfu_vld_p1 <= 1'b0;
            op_vld_p1  <= 1'b0;
        end else begin
            if (pop)                               vfu_vld_p1 <= 1'b1;
            else if (vfu_req_ready_i[target_p1])   vfu_vld_p1 <= 1'b0;
            if (pop)                               op_vld_p1  <= (head.use_vs != 2'b00);
            else if (op_req_ready_i)               op_vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop) begin
            target_p1  <= GetVFUByVOp(head.vop);
            vfu_req_p1 <= '{vop: head.vop, vd: head.vd, waddr: GetVRFAddr(head.vd), vl: head.vl};
            op_req_p1  <= '{vs1: head.vs1, vs2: head.vs2, use_vs: head.use_vs,
                            queue_req: GetOpQueue(head.vop, head.use_vs), vl: head.vl};
        end
    end

    assign vfu_req_valid_o = vfu_vld_p1;
    assign target_vfu_o    = target_p1;
    assign vfu_req_o       = vfu_req_p1;
    assign op_req_valid_o  = op_vld_p1;
    assign op_req_o        = op_req_p1;
    assign queue_empty_o   = !head_vld && !vfu_vld_p1 && !op_vld_p1;

`ifdef VINSN_DISPATCH_PERF_EN
    logic [CntWidth-1:0] perf_hazard_q, perf_backpr_q, perf_disp_q;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_hazard_q <= '0;
            perf_backpr_q <= '0;
            perf_disp_q   <= '0;
        end else begin
            if (head_vld && hazard)               perf_hazard_q <= sat_inc(perf_hazard_q);
            if (head_vld && !hazard && !slot_free) perf_backpr_q <= sat_inc(perf_backpr_q);
            if (pop)                              perf_disp_q   <= sat_inc(perf_disp_q);
        end
    end

    assign perf_hazard_o = perf_hazard_q;
    assign perf_backpr_o = perf_backpr_q;
    assign perf_disp_o   = perf_disp_q;
`else
    assign perf_hazard_o = '0;
    assign perf_backpr_o = '0;
    assign perf_disp_o   = '0;
`endif

endmodule

// File: tb/tb_vinsn_dispatch_queue.sv
// Scoreboard bench for vinsn_dispatch_queue: expected requests are queued when
// instructions are driven and compared at each VFU / operand handshake.
module tb_vinsn_dispatch_queue;
    import vinsn_dispatch_queue_pkg::*;

    localparam int unsigned QueueDepth = 4;
    localparam int unsigned CntWidth   = 32;
`ifdef VINSN_DISPATCH_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    typedef struct packed {
        vfu_e     tgt;
        vfu_req_t req;
    } exp_vfu_t;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  flush_i = 1'b0;
    logic                  issue_req_valid_i = 1'b0;
    logic                  issue_req_ready_o;
    issue_req_t            issue_req_i = '0;
    logic [NrVFU-1:0]      vfu_req_ready_i = '1;
    logic                  vfu_req_valid_o;
    vfu_e                  target_vfu_o;
    vfu_req_t              vfu_req_o;
    logic                  op_req_ready_i = 1'b1;
    logic                  op_req_valid_o;
    op_req_t               op_req_o;
    logic [NrVFU-1:0]      vfu_done_i = '0;
    logic [NrVFU-1:0]      vfu_use_vd_i = '0;
    vreg_t [NrVFU-1:0]     vfu_vd_i = '0;
    logic [NrOpQueue-1:0]  op_access_done_i = '0;
    vreg_t [NrOpQueue-1:0] op_access_vs_i = '0;
    logic                  queue_empty_o;
    logic [CntWidth-1:0]   perf_hazard_o, perf_backpr_o, perf_disp_o;

    int checks = 0;
    int errors = 0;
    exp_vfu_t exp_vfu_q[$];
    op_req_t  exp_op_q[$];
    exp_vfu_t mon_ev;
    op_req_t  mon_eo;

    vinsn_dispatch_queue #(
        .QueueDepth (QueueDepth),
        .NrVRegs    (32),
        .CntWidth   (CntWidth)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .issue_req_valid_i (issue_req_valid_i),
        .issue_req_ready_o (issue_req_ready_o),
        .issue_req_i       (issue_req_i),
        .vfu_req_ready_i   (vfu_req_ready_i),
        .vfu_req_valid_o   (vfu_req_valid_o),
        .target_vfu_o      (target_vfu_o),
        .vfu_req_o         (vfu_req_o),
        .op_req_ready_i    (op_req_ready_i),
        .op_req_valid_o    (op_req_valid_o),
        .op_req_o          (op_req_o),
        .vfu_done_i        (vfu_done_i),
        .vfu_use_vd_i      (vfu_use_vd_i),
        .vfu_vd_i          (vfu_vd_i),
        .op_access_done_i  (op_access_done_i),
        .op_access_vs_i    (op_access_vs_i),
        .queue_empty_o     (queue_empty_o),
        .perf_hazard_o     (perf_hazard_o),
        .perf_backpr_o     (perf_backpr_o),
        .perf_disp_o       (perf_disp_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic issue_req_t mk(input vop_e vop, input int vd, input int vs1, input int vs2,
                                      input logic [1:0] use_vs);
        issue_req_t r;
        r.vop    = vop;
        r.vd     = vreg_t'(vd);
        r.vs1    = vreg_t'(vs1);
        r.vs2    = vreg_t'(vs2);
        r.use_vs = use_vs;
        r.vl     = vlen_t'(16 + vd);
        return r;
    endfunction

    function automatic op_req_t model_op(input issue_req_t r);
        op_req_t o;
        o.vs1       = r.vs1;
        o.vs2       = r.vs2;
        o.use_vs    = r.use_vs;
        o.queue_req = r.use_vs;
        o.vl        = r.vl;
        return o;
    endfunction

    task automatic expect_insn(input issue_req_t r);
        exp_vfu_t e;
        e.tgt       = (r.vop == VOP_MUL || r.vop == VOP_MACC) ? VFU_MUL : VFU_ALU;
        e.req.vop   = r.vop;
        e.req.vd    = r.vd;
        e.req.waddr = vrf_addr_t'(r.vd) * 8'd8;
        e.req.vl    = r.vl;
        exp_vfu_q.push_back(e);
        if (r.use_vs != 2'b00) exp_op_q.push_back(model_op(r));
    endtask

    // Handshake monitor: sampled mid-cycle, so the handshake completes at the next rising edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (vfu_req_valid_o && vfu_req_ready_i[target_vfu_o]) begin
                checks++;
                if (exp_vfu_q.size() == 0) begin
                    errors++;
                    $display("FAIL vfu_unexpected got vd=%0d expected none", vfu_req_o.vd);
                end else begin
                    mon_ev = exp_vfu_q.pop_front();
                    if ({target_vfu_o, vfu_req_o} !== {mon_ev.tgt, mon_ev.req}) begin
                        errors++;
                        $display("FAIL vfu_payload got %h expected %h", {target_vfu_o, vfu_req_o},
                                 {mon_ev.tgt, mon_ev.req});
                    end
                end
            end
            if (op_req_valid_o && op_req_ready_i) begin
                checks++;
                if (exp_op_q.size() == 0) begin
                    errors++;
                    $display("FAIL op_unexpected got %h expected none", op_req_o);
                end else begin
                    mon_eo = exp_op_q.pop_front();
                    if (op_req_o !== mon_eo) begin
                        errors++;
                        $display("FAIL op_payload got %h expected %h", op_req_o, mon_eo);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        flush_i = 1'b0;
        issue_req_valid_i = 1'b0;
        vfu_req_ready_i = '1;
        op_req_ready_i = 1'b1;
        vfu_done_i = '0;
        vfu_use_vd_i = '0;
        vfu_vd_i = '0;
        op_access_done_i = '0;
        op_access_vs_i = '0;
        exp_vfu_q.delete();
        exp_op_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    // Drives one request until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input issue_req_t r, input bit keep);
        bit ok;
        ok = 1'b0;
        issue_req_valid_i = 1'b1;
        issue_req_i = r;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (issue_req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout vd=%0d ready=%0b required 1", r.vd, issue_req_ready_o);
        end
        if (keep) expect_insn(r);
        @(posedge clk_i);
        #1 issue_req_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && (exp_vfu_q.size() != 0 || exp_op_q.size() != 0); i++) @(posedge clk_i);
        #1;
        checks++;
        if (exp_vfu_q.size() != 0 || exp_op_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending vfu=%0d op=%0d required 0 0", name, exp_vfu_q.size(), exp_op_q.size());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        checks += 5;
        if (queue_empty_o !== 1'b1)     begin errors++; $display("FAIL rst_empty got %b required 1", queue_empty_o); end
        if (issue_req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b required 1", issue_req_ready_o); end
        if (vfu_req_valid_o !== 1'b0)   begin errors++; $display("FAIL rst_vfu_valid got %b required 0", vfu_req_valid_o); end
        if (op_req_valid_o !== 1'b0)    begin errors++; $display("FAIL rst_op_valid got %b required 0", op_req_valid_o); end
        if ({perf_hazard_o, perf_backpr_o, perf_disp_o} !== '0) begin
            errors++;
            $display("FAIL rst_perf got %0d %0d %0d required 0 0 0", perf_hazard_o, perf_backpr_o, perf_disp_o);
        end
        do_reset();
        checks++;
        if (issue_req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b required 1", issue_req_ready_o); end
    endtask

    task automatic test_back_to_back();
        issue_req_t r [3];
        logic exp_vld [4];
        int exp_vd [4];
        do_reset();
        r[0] = mk(VOP_ADD, 1, 9, 0, 2'b01);
        r[1] = mk(VOP_MUL, 2, 10, 11, 2'b11);
        r[2] = mk(VOP_SUB, 3, 0, 12, 2'b10);
        exp_vld = '{1'b0, 1'b1, 1'b1, 1'b1};
        exp_vd  = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                issue_req_valid_i = 1'b1;
                issue_req_i = r[i];
                expect_insn(r[i]);
            end else begin
                issue_req_valid_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            checks++;
            if (vfu_req_valid_o !== exp_vld[i] || (exp_vld[i] && vfu_req_o.vd !== vreg_t'(exp_vd[i]))) begin
                errors++;
                $display("FAIL b2b_cycle%0d got valid=%b vd=%0d required valid=%b vd=%0d", i, vfu_req_valid_o,
                         vfu_req_o.vd, exp_vld[i], exp_vd[i]);
            end
        end
        @(posedge clk_i);
        #1;
        checks += 2;
        if (vfu_req_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b required 0", vfu_req_valid_o); end
        if (perf_disp_o !== (PerfEn ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL b2b_perf_disp got %0d required %0d", perf_disp_o, PerfEn ? 3 : 0);
        end
        wait_drain("b2b");
    endtask

    task automatic test_fill();
        issue_req_t r;
        do_reset();
        vfu_req_ready_i = '0;
        for (int i = 1; i <= QueueDepth + 1; i++) send(mk(VOP_ADD, i, 15 + i, 0, 2'b01), 1'b1);
        checks++;
        if (issue_req_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full got %b required 0", issue_req_ready_o); end
        r = mk(VOP_OR, 6, 22, 0, 2'b01);
        issue_req_valid_i = 1'b1;
        issue_req_i = r;
        expect_insn(r);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (issue_req_ready_o !== 1'b0) begin errors++; $display("FAIL fill_hold%0d got %b required 0", i, issue_req_ready_o); end
        end
        @(posedge clk_i);
        #1 vfu_req_ready_i = '1;
        @(negedge clk_i);
        checks++;
        if (issue_req_ready_o !== 1'b0) begin errors++; $display("FAIL fill_no_fallthrough got %b required 0", issue_req_ready_o); end
        @(posedge clk_i);
        #1;
        checks++;
        if (issue_req_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got %b required 1", issue_req_ready_o); end
        @(posedge clk_i);
        #1 issue_req_valid_i = 1'b0;
        wait_drain("fill");
    endtask

    task automatic test_raw();
        do_reset();
        send(mk(VOP_ADD, 5, 1, 0, 2'b01), 1'b1);
        send(mk(VOP_ADD, 6, 0, 5, 2'b10), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (vfu_req_valid_o !== 1'b0) begin errors++; $display("FAIL raw_stall%0d got %b required 0", i, vfu_req_valid_o); end
        end
        vfu_done_i = 2'b01;
        vfu_use_vd_i = 2'b01;
        vfu_vd_i[0] = vreg_t'(5);
        @(posedge clk_i);
        #1;
        vfu_done_i = '0;
        vfu_use_vd_i = '0;
        checks++;
        if (vfu_req_valid_o !== 1'b0) begin errors++; $display("FAIL raw_done_cycle got %b required 0", vfu_req_valid_o); end
        @(posedge clk_i);
        #1;
        checks += 2;
        if (vfu_req_valid_o !== 1'b1 || vfu_req_o.vd !== vreg_t'(6)) begin
            errors++;
            $display("FAIL raw_release got valid=%b vd=%0d required valid=1 vd=6", vfu_req_valid_o, vfu_req_o.vd);
        end
        if (perf_hazard_o !== (PerfEn ? 32'd4 : 32'd0)) begin
            errors++;
            $display("FAIL raw_perf_hazard got %0d required %0d", perf_hazard_o, PerfEn ? 4 : 0);
        end
        wait_drain("raw");
    endtask

    task automatic test_op_stall();
        issue_req_t r1;
        op_req_t eo;
        do_reset();
        op_req_ready_i = 1'b0;
        r1 = mk(VOP_AND, 8, 20, 0, 2'b01);
        eo = model_op(r1);
        send(r1, 1'b1);
        send(mk(VOP_OR, 9, 0, 0, 2'b00), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (op_req_valid_o !== 1'b1 || op_req_o !== eo) begin
                errors++;
                $display("FAIL opstall_hold%0d got valid=%b req=%h required valid=1 req=%h", i, op_req_valid_o, op_req_o, eo);
            end
        end
        checks++;
        if (vfu_req_valid_o !== 1'b0) begin errors++; $display("FAIL opstall_vfu_cleared got %b required 0", vfu_req_valid_o); end
        op_req_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks += 2;
        if (vfu_req_valid_o !== 1'b1 || vfu_req_o.vd !== vreg_t'(9) || op_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL opstall_next got vfu=%b vd=%0d op=%b required vfu=1 vd=9 op=0", vfu_req_valid_o,
                     vfu_req_o.vd, op_req_valid_o);
        end
        if (perf_backpr_o !== (PerfEn ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL opstall_perf_backpr got %0d required %0d", perf_backpr_o, PerfEn ? 3 : 0);
        end
        wait_drain("opstall");
    endtask

    task automatic test_flush();
        do_reset();
        vfu_req_ready_i = '0;
        send(mk(VOP_ADD, 10, 24, 0, 2'b01), 1'b1);
        for (int i = 11; i <= 13; i++) send(mk(VOP_ADD, i, 14 + i, 0, 2'b01), 1'b0);
        flush_i = 1'b1;
        issue_req_valid_i = 1'b1;
        issue_req_i = mk(VOP_SUB, 14, 28, 0, 2'b01);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        issue_req_valid_i = 1'b0;
        checks += 2;
        if (issue_req_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %b required 1", issue_req_ready_o); end
        if (queue_empty_o !== 1'b0)     begin errors++; $display("FAIL flush_empty_pending got %b required 0", queue_empty_o); end
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (vfu_req_valid_o !== 1'b1 || queue_empty_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_output_held got valid=%b empty=%b required 1 0", vfu_req_valid_o, queue_empty_o);
        end
        vfu_req_ready_i = '1;
        @(posedge clk_i);
        #1;
        checks++;
        if (queue_empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty_after got %b required 1", queue_empty_o); end
        repeat (5) @(posedge clk_i);
        #1;
        checks++;
        if (vfu_req_valid_o !== 1'b0 || op_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_leak got vfu=%b op=%b required 0 0", vfu_req_valid_o, op_req_valid_o);
        end
        wait_drain("flush");
    endtask

    task automatic test_set_clear();
        do_reset();
        send(mk(VOP_ADD, 7, 2, 0, 2'b01), 1'b1);
        vfu_done_i = 2'b01;
        vfu_use_vd_i = 2'b01;
        vfu_vd_i[0] = vreg_t'(7);
        send(mk(VOP_ADD, 14, 7, 0, 2'b01), 1'b1);
        vfu_done_i = '0;
        vfu_use_vd_i = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (vfu_req_valid_o !== 1'b0) begin errors++; $display("FAIL setclr_stall%0d got %b required 0", i, vfu_req_valid_o); end
        end
        vfu_done_i = 2'b01;
        vfu_use_vd_i = 2'b01;
        @(posedge clk_i);
        #1;
        vfu_done_i = '0;
        vfu_use_vd_i = '0;
        @(posedge clk_i);
        #1;
        checks++;
        if (vfu_req_valid_o !== 1'b1 || vfu_req_o.vd !== vreg_t'(14)) begin
            errors++;
            $display("FAIL setclr_release got valid=%b vd=%0d required valid=1 vd=14", vfu_req_valid_o, vfu_req_o.vd);
        end
        wait_drain("setclr");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill();
        test_raw();
        test_op_stall();
        test_flush();
        test_set_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
